line_burst_adapter: RTL and testbench

Sits directly downstream of the cache group's bottom write-evict buffer, between the 256-bit cache-line port and physical memory. Converts each line read or write into a 4-beat, 64-bit burst on a narrow memory bus. Buffers the full line in both directions. Presents the cache-side 256-bit resp/rdata handshake unchanged to the cache group.

---
 rtl/line_burst_adapter.sv | 89 ++++++++
 tb/tb_line_burst_adapter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/line_burst_adapter.sv
// line_burst_adapter: moves 256-bit cache lines to and from memory as fixed-order 4-beat 64-bit bursts
// Both directions are fully buffered, so the cache side sees a single line_resp pulse per line.
module line_burst_adapter #(
   parameter int BEAT_WIDTH = 64,
   parameter int BEATS      = 4,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           line_read,
   input  logic                           line_write,
   input  logic [ADDR_WIDTH-1:0]          line_address,
   input  logic [BEAT_WIDTH*BEATS-1:0]    line_wdata,
   output logic [BEAT_WIDTH*BEATS-1:0]    line_rdata,
   output logic                           line_resp,
   output logic                           mem_read,
   output logic                           mem_write,
   output logic [ADDR_WIDTH-1:0]          mem_address,
   output logic [BEAT_WIDTH-1:0]          mem_wdata,
   input  logic [BEAT_WIDTH-1:0]          mem_rdata,
   input  logic                           mem_resp
);
   localparam int LINE_W = BEAT_WIDTH*BEATS;
   localparam int CW = $clog2(BEATS);
   localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(LINE_W/8 - 1);
   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
   state_t                state_q;
   logic [CW-1:0]         cnt_q;
   logic [LINE_W-1:0]     rdata_q, wbuf_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  resp_q, rd_q, wr_q;
   logic                  last;
   assign last        = cnt_q == CW'(BEATS-1);
   assign line_rdata  = rdata_q;
   assign line_resp   = resp_q;
   assign mem_read    = rd_q;
   assign mem_write   = wr_q;
   assign mem_address = addr_q;
   assign mem_wdata   = wbuf_q[BEAT_WIDTH*cnt_q +: BEAT_WIDTH];
   // Requests are sampled only in IDLE; DONE always costs one cycle before the next capture.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
         wbuf_q  <= '0;
         addr_q  <= '0;
         resp_q  <= 1'b0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
      end else
         case (state_q)
            IDLE:
               if (line_read) begin
                  addr_q  <= line_address & ~OFF_MASK;
                  rd_q    <= 1'b1;
                  state_q <= RD;
               end else if (line_write) begin
                  addr_q  <= line_address & ~OFF_MASK;
                  wbuf_q  <= line_wdata;
                  wr_q    <= 1'b1;
                  state_q <= WR;
               end
            RD:
               if (mem_resp) begin
                  rdata_q[BEAT_WIDTH*cnt_q +: BEAT_WIDTH] <= mem_rdata;
                  cnt_q <= last ? '0 : cnt_q + 1'b1;
                  if (last) begin
                     rd_q    <= 1'b0;
                     resp_q  <= 1'b1;
                     state_q <= DONE;
                  end
               end
            WR:
               if (mem_resp) begin
                  cnt_q <= last ? '0 : cnt_q + 1'b1;
                  if (last) begin
                     wr_q    <= 1'b0;
                     resp_q  <= 1'b1;
                     state_q <= DONE;
                  end
               end
            DONE: begin
               resp_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
endmodule

// File: tb/tb_line_burst_adapter.sv
// tb_line_burst_adapter: random line traffic against a memory model, scoreboard-checked
// Reference memory tracks lines at cache granularity; a separate responder plays the memory device.
module tb_line_burst_adapter;
   logic         clk = 1'b0;
   logic         rst;
   logic         line_read, line_write;
   logic [31:0]  line_address;
   logic [255:0] line_wdata, line_rdata;
   logic         line_resp, mem_read, mem_write;
   logic [31:0]  mem_address;
   logic [63:0]  mem_wdata, mem_rdata;
   logic         mem_resp;

   line_burst_adapter dut (
      .clk(clk), .rst(rst),
      .line_read(line_read), .line_write(line_write),
      .line_address(line_address), .line_wdata(line_wdata),
      .line_rdata(line_rdata), .line_resp(line_resp),
      .mem_read(mem_read), .mem_write(mem_write),
      .mem_address(mem_address), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_resp(mem_resp)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit           rd;
      logic [31:0]  addr;
      logic [255:0] data;
   } txn_t;

   int           checks = 0;
   int           failures = 0;
   txn_t         exp_q[$];
   logic [63:0]  exp_beats[$];
   logic [63:0]  wlog[$];
   bit           pat[$];
   bit           zw = 1'b0;
   bit           stray = 1'b0;
   logic [255:0] ref_mem [logic [31:0]];
   logic [255:0] dev [logic [31:0]];
   logic [1:0]   rbeat;
   logic [255:0] ln;
   txn_t         mt;

   task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
      end
   endtask

   function automatic logic [255:0] rand_line();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   // Memory device: serves read beats from dev[], stores write beats, honours gap patterns.
   initial begin
      mem_resp = 1'b0;
      mem_rdata = '0;
      rbeat = '0;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            mem_resp = 1'b0;
            rbeat = '0;
         end else if (stray) begin
            mem_resp = 1'b1;
            mem_rdata = {$urandom, $urandom};
         end else if (mem_read || mem_write) begin
            if (pat.size() > 0) mem_resp = pat.pop_front();
            else mem_resp = zw || ($urandom_range(0, 3) != 0);
            mem_rdata = {$urandom, $urandom};
            if (mem_resp) begin
               ln = dev.exists(mem_address) ? dev[mem_address] : '0;
               if (mem_read) mem_rdata = ln[64*rbeat +: 64];
               else begin
                  ln[64*rbeat +: 64] = mem_wdata;
                  dev[mem_address] = ln;
               end
               rbeat++;
            end
         end else mem_resp = 1'b0;
      end
   end

   // Monitor: compares DUT activity against the head of the scoreboard.
   always @(negedge clk) begin
      if (mem_write) wlog.push_back(mem_wdata);
      if (exp_q.size() == 0) begin
         chk("idle_resp", 256'(line_resp), '0);
         chk("idle_burst", 256'(mem_read | mem_write), '0);
      end else begin
         mt = exp_q[0];
         if (mem_read | mem_write) begin
            chk("mem_address", 256'(mem_address), 256'(mt.addr));
            chk("burst_kind", 256'(mem_read), 256'(mt.rd));
            chk("rd_wr_exclusive", 256'(mem_read & mem_write), '0);
         end
         if (mem_write && mem_resp) begin
            if (exp_beats.size() == 0) chk("extra_wbeat", 256'(mem_write), '0);
            else chk("wbeat", 256'(mem_wdata), 256'(exp_beats.pop_front()));
         end
         if (line_resp) begin
            void'(exp_q.pop_front());
            if (mt.rd) chk("line_rdata", line_rdata, mt.data);
            else chk("wbeats_left", 256'(exp_beats.size()), '0);
         end
      end
   end

   task automatic init_line(input logic [31:0] la);
      logic [255:0] r;
      if (!ref_mem.exists(la)) begin
         r = rand_line();
         ref_mem[la] = r;
         dev[la] = r;
      end
   endtask

   task automatic issue(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [255:0] wd, output int n);
      txn_t t;
      logic [31:0] la;
      la = a & ~32'h1f;
      init_line(la);
      t.rd = rd;
      t.addr = la;
      t.data = rd ? ref_mem[la] : wd;
      if (!rd) begin
         for (int i = 0; i < 4; i++) exp_beats.push_back(wd[64*i +: 64]);
         ref_mem[la] = wd;
      end
      exp_q.push_back(t);
      line_read = rd;
      line_write = wr;
      line_address = a;
      line_wdata = wd;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            chk("burst_start", 256'(rd ? mem_read : mem_write), 256'(1));
            line_address = $urandom;
            line_wdata = rand_line();
         end
      end while (!line_resp && n < 400);
      if (n >= 400) chk("resp_timeout", 256'(line_resp), 256'(1));
      line_read = 1'b0;
      line_write = 1'b0;
      @(negedge clk);
      chk("resp_single_cycle", 256'(line_resp), '0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1);
   end

   initial begin
      int n, kind;
      logic [31:0]  a;
      logic [255:0] wd;
      logic [31:0]  lines [4];
      int           idx [7];
      lines = '{32'h0000_0100, 32'h0000_0200, 32'h0000_1000, 32'hABCD_E000};
      idx = '{0, 1, 1, 1, 2, 3, 3};
      rst = 1'b1;
      line_read = 1'b0;
      line_write = 1'b0;
      line_address = '0;
      line_wdata = '0;
      repeat (3) @(negedge clk);
      chk("rst_mem_read", 256'(mem_read), '0);
      chk("rst_mem_write", 256'(mem_write), '0);
      chk("rst_line_resp", 256'(line_resp), '0);
      chk("rst_mem_address", 256'(mem_address), '0);
      chk("rst_line_rdata", line_rdata, '0);
      rst = 1'b0;
      @(negedge clk);

      zw = 1'b1;
      ref_mem[32'h1220] = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
      dev[32'h1220] = ref_mem[32'h1220];
      issue(1'b1, 1'b0, 32'h0000_1234, '0, n);
      chk("zero_wait_latency", 256'(n), 256'(5));
      zw = 1'b0;

      wlog.delete();
      pat = '{1, 0, 0, 1, 1, 0, 1};
      wd = rand_line();
      issue(1'b0, 1'b1, 32'h0000_0040, wd, n);
      chk("gap_write_latency", 256'(n), 256'(8));
      chk("gap_wlog_len", 256'(wlog.size()), 256'(7));
      if (wlog.size() == 7)
         for (int i = 0; i < 7; i++) chk("gap_wdata_step", 256'(wlog[i]), 256'(wd[64*idx[i] +: 64]));

      issue(1'b1, 1'b1, 32'h0000_1040, rand_line(), n);

      init_line(32'h0000_3000);
      pat = '{1, 1, 0, 0, 0, 0};
      mt.rd = 1'b1;
      exp_q.push_back('{rd: 1'b1, addr: 32'h0000_3000, data: ref_mem[32'h3000]});
      line_read = 1'b1;
      line_address = 32'h0000_3000;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      line_read = 1'b0;
      #1;
      chk("midrst_mem_read", 256'(mem_read), '0);
      chk("midrst_line_resp", 256'(line_resp), '0);
      chk("midrst_line_rdata", line_rdata, '0);
      exp_q.delete();
      exp_beats.delete();
      pat.delete();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      stray = 1'b1;
      @(negedge clk);
      stray = 1'b0;
      repeat (2) @(negedge clk);
      issue(1'b1, 1'b0, 32'h0000_3008, '0, n);

      issue(1'b1, 1'b0, 32'h0000_0100, '0, n);
      wd = rand_line();
      issue(1'b0, 1'b1, 32'h0000_0200, wd, n);
      issue(1'b1, 1'b0, 32'h0000_0200, '0, n);

      stray = 1'b1;
      repeat (3) @(negedge clk);
      stray = 1'b0;
      repeat (2) @(negedge clk);
      issue(1'b1, 1'b0, 32'h0000_0040, '0, n);

      for (int k = 0; k < 40; k++) begin
         kind = $urandom_range(0, 2);
         a = lines[$urandom_range(0, 3)] | ($urandom & 32'h1f);
         issue(kind != 1, kind != 0, a, rand_line(), n);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 256'(exp_q.size()), '0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
